// File: rtl/core_ctx_sched.sv
// core_ctx_sched: multi-context task scheduler for one core.
// Dequeues tasks into free contexts, reports start/finish to the CQ through two
// round-robin arbiters, and handles per-context abort and memory drain.
module core_ctx_sched #(
    parameter int unsigned N_CTX    = 4,
    parameter int unsigned SLOT_W   = 7,
    parameter int unsigned TASK_W   = 128,
    parameter int unsigned THREAD_W = 4,
    parameter int unsigned CHILD_W  = 3,
    parameter int unsigned RST_HOLD = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_en,
    input  logic                    cfg_deq_valid,
    input  logic [31:0]             cfg_deq_count,
    output logic                    task_arvalid,
    input  logic                    task_rvalid,
    input  logic [TASK_W-1:0]       task_rdata,
    input  logic [SLOT_W-1:0]       task_rslot,
    input  logic [THREAD_W-1:0]     task_rthread,
    output logic                    start_task_valid,
    input  logic                    start_task_ready,
    output logic [SLOT_W-1:0]       start_task_slot,
    output logic                    finish_task_valid,
    input  logic                    finish_task_ready,
    output logic [SLOT_W-1:0]       finish_task_slot,
    output logic [THREAD_W-1:0]     finish_task_thread,
    output logic [CHILD_W-1:0]      finish_task_num_children,
    output logic                    finish_task_undo_log_write,
    input  logic [2**SLOT_W-1:0]    task_aborted,
    input  logic [N_CTX-1:0]        ctx_enq_fire,
    input  logic [N_CTX-1:0]        ctx_undo_fire,
    input  logic [N_CTX-1:0]        ctx_out_busy,
    input  logic [N_CTX-1:0]        ctx_mem_pending,
    output logic [N_CTX-1:0]        app_start,
    output logic [N_CTX*TASK_W-1:0] app_task,
    input  logic [N_CTX-1:0]        app_done,
    input  logic [N_CTX-1:0]        app_idle,
    output logic [N_CTX-1:0]        app_rst,
    output logic [N_CTX-1:0]        ctx_busy,
    output logic [31:0]             num_dequeues
);
    localparam int unsigned PTR_W = (N_CTX > 1) ? $clog2(N_CTX) : 1;
    localparam int unsigned CNT_W = $clog2(RST_HOLD + 1);

    typedef enum logic [2:0] {
        StIdle, StInform, StRun, StAbortRst, StAbortWait, StFinish, StDrain
    } ctx_state_e;

    ctx_state_e          state_q  [N_CTX];
    ctx_state_e          state_d  [N_CTX];
    logic [TASK_W-1:0]   task_q   [N_CTX];
    logic [TASK_W-1:0]   task_d   [N_CTX];
    logic [SLOT_W-1:0]   slot_q   [N_CTX];
    logic [SLOT_W-1:0]   slot_d   [N_CTX];
    logic [THREAD_W-1:0] thread_q [N_CTX];
    logic [THREAD_W-1:0] thread_d [N_CTX];
    logic [CHILD_W-1:0]  child_q  [N_CTX];
    logic [CHILD_W-1:0]  child_d  [N_CTX];
    logic [CNT_W-1:0]    hold_q   [N_CTX];
    logic [CNT_W-1:0]    hold_d   [N_CTX];
    logic [N_CTX-1:0]    undo_q, undo_d, abort_q, abort_d;
    logic [N_CTX-1:0]    app_start_q, app_start_d, app_rst_q, app_rst_d;
    logic [31:0]         budget_q, budget_d, ndeq_q, ndeq_d;
    logic [PTR_W-1:0]    s_ptr_q, s_ptr_d, f_ptr_q, f_ptr_d;
    logic [PTR_W-1:0]    s_lgnt_q, s_lgnt_d, f_lgnt_q, f_lgnt_d;
    logic                s_lock_q, s_lock_d, f_lock_q, f_lock_d;
    logic [N_CTX-1:0]    idle_vec, s_req, f_req;
    logic [PTR_W-1:0]    deq_idx, s_gnt, f_gnt;
    logic                deq_ok, s_valid, f_valid, deq_fire, s_fire, f_fire;

    // First requester at or after ptr, wrapping around.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [N_CTX-1:0] req,
                                                 input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < int'(N_CTX); k++) begin
            idx = (int'(ptr) + k) % int'(N_CTX);
            if (!found && req[idx]) begin
                pick  = PTR_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] g);
        return (int'(g) == int'(N_CTX) - 1) ? '0 : g + 1'b1;
    endfunction

    // Request vectors, dequeue target, arbiter grants and handshakes
    always_comb begin
        idle_vec = '0;
        s_req    = '0;
        f_req    = '0;
        deq_idx  = '0;
        for (int i = 0; i < int'(N_CTX); i++) begin
            idle_vec[i] = (state_q[i] == StIdle);
            s_req[i]    = (state_q[i] == StInform);
            // A finish beat already presented stays eligible until accepted
            f_req[i]    = (state_q[i] == StFinish) &&
                          (!ctx_out_busy[i] || (f_lock_q && f_lgnt_q == PTR_W'(i)));
        end
        for (int i = int'(N_CTX) - 1; i >= 0; i--) begin
            if (idle_vec[i]) deq_idx = PTR_W'(i);
        end
        deq_ok   = start_en && !rst && (budget_q != 32'd0) && (|idle_vec);
        s_valid  = |s_req;
        f_valid  = |f_req;
        s_gnt    = s_lock_q ? s_lgnt_q : rr_pick(s_req, s_ptr_q);
        f_gnt    = f_lock_q ? f_lgnt_q : rr_pick(f_req, f_ptr_q);
        deq_fire = deq_ok && task_rvalid;
        s_fire   = s_valid && start_task_ready;
        f_fire   = f_valid && finish_task_ready;
    end

    // Per-context next state
    always_comb begin
        for (int i = 0; i < int'(N_CTX); i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                StIdle:      if (deq_fire && deq_idx == PTR_W'(i)) state_d[i] = StInform;
                StInform:    if (s_fire && s_gnt == PTR_W'(i))
                                 state_d[i] = abort_q[i] ? StFinish : StRun;
                StRun:       if (app_done[i]) state_d[i] = StFinish;
                             else if (abort_q[i]) state_d[i] = StAbortRst;
                StAbortRst:  if (hold_q[i] == CNT_W'(RST_HOLD - 1)) state_d[i] = StAbortWait;
                StAbortWait: if (app_idle[i]) state_d[i] = StFinish;
                StFinish:    if (f_fire && f_gnt == PTR_W'(i))
                                 state_d[i] = ctx_mem_pending[i] ? StDrain : StIdle;
                StDrain:     if (!ctx_mem_pending[i]) state_d[i] = StIdle;
                default:     state_d[i] = StIdle;
            endcase
        end
    end

    // Context data, budget/counters and arbiter bookkeeping
    always_comb begin
        logic deq_here;
        logic run_or_inf;
        deq_here   = 1'b0;
        run_or_inf = 1'b0;
        budget_d   = budget_q;
        if (cfg_deq_valid) budget_d = cfg_deq_count;
        else if (deq_fire) budget_d = budget_q - 32'd1;
        ndeq_d   = deq_fire ? ndeq_q + 32'd1 : ndeq_q;
        s_ptr_d  = s_fire ? rr_next(s_gnt) : s_ptr_q;
        f_ptr_d  = f_fire ? rr_next(f_gnt) : f_ptr_q;
        // Hold the grant while a beat waits so the presented fields stay stable
        s_lock_d = s_valid && !start_task_ready;
        f_lock_d = f_valid && !finish_task_ready;
        s_lgnt_d = s_gnt;
        f_lgnt_d = f_gnt;
        for (int i = 0; i < int'(N_CTX); i++) begin
            deq_here    = deq_fire && (deq_idx == PTR_W'(i));
            run_or_inf  = (state_q[i] == StInform) || (state_q[i] == StRun);
            task_d[i]   = deq_here ? task_rdata   : task_q[i];
            slot_d[i]   = deq_here ? task_rslot   : slot_q[i];
            thread_d[i] = deq_here ? task_rthread : thread_q[i];
            child_d[i]  = child_q[i];
            undo_d[i]   = undo_q[i];
            if (deq_here) begin
                child_d[i] = '0;
                undo_d[i]  = 1'b0;
            end else if (state_q[i] != StIdle) begin
                if (ctx_enq_fire[i] && child_q[i] != '1) child_d[i] = child_q[i] + 1'b1;
                if (ctx_undo_fire[i]) undo_d[i] = 1'b1;
            end
            // Completion in the same cycle as an abort takes precedence
            abort_d[i] = (state_d[i] == StIdle) ? 1'b0 :
                         abort_q[i] | (task_aborted[slot_q[i]] && run_or_inf &&
                                       !((state_q[i] == StRun) && app_done[i]));
            hold_d[i]      = (state_q[i] == StAbortRst) ? hold_q[i] + 1'b1 : '0;
            app_start_d[i] = s_fire && (s_gnt == PTR_W'(i)) && !abort_q[i];
            app_rst_d[i]   = (state_d[i] == StAbortRst);
        end
    end

    // Outputs
    always_comb begin
        task_arvalid               = deq_ok;
        start_task_valid           = s_valid;
        start_task_slot            = slot_q[s_gnt];
        finish_task_valid          = f_valid;
        finish_task_slot           = slot_q[f_gnt];
        finish_task_thread         = thread_q[f_gnt];
        finish_task_num_children   = child_q[f_gnt];
        finish_task_undo_log_write = undo_q[f_gnt];
        app_start                  = app_start_q;
        app_rst                    = app_rst_q;
        num_dequeues               = ndeq_q;
        ctx_busy                   = '0;
        app_task                   = '0;
        for (int i = 0; i < int'(N_CTX); i++) begin
            ctx_busy[i]                    = (state_q[i] != StIdle);
            app_task[i*TASK_W +: TASK_W]   = task_q[i];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N_CTX); i++) begin
                state_q[i]  <= StIdle;
                task_q[i]   <= '0;
                slot_q[i]   <= '0;
                thread_q[i] <= '0;
                child_q[i]  <= '0;
                hold_q[i]   <= '0;
            end
            undo_q      <= '0;
            abort_q     <= '0;
            app_start_q <= '0;
            app_rst_q   <= '1;
            budget_q    <= 32'hFFFF_FFFF;
            ndeq_q      <= '0;
            s_ptr_q     <= '0;
            f_ptr_q     <= '0;
            s_lgnt_q    <= '0;
            f_lgnt_q    <= '0;
            s_lock_q    <= 1'b0;
            f_lock_q    <= 1'b0;
        end else begin
            for (int i = 0; i < int'(N_CTX); i++) begin
                state_q[i]  <= state_d[i];
                task_q[i]   <= task_d[i];
                slot_q[i]   <= slot_d[i];
                thread_q[i] <= thread_d[i];
                child_q[i]  <= child_d[i];
                hold_q[i]   <= hold_d[i];
            end
            undo_q      <= undo_d;
            abort_q     <= abort_d;
            app_start_q <= app_start_d;
            app_rst_q   <= app_rst_d;
            budget_q    <= budget_d;
            ndeq_q      <= ndeq_d;
            s_ptr_q     <= s_ptr_d;
            f_ptr_q     <= f_ptr_d;
            s_lgnt_q    <= s_lgnt_d;
            f_lgnt_q    <= f_lgnt_d;
            s_lock_q    <= s_lock_d;
            f_lock_q    <= f_lock_d;
        end
    end

endmodule

// File: tb/tb_core_ctx_sched.sv
// Directed bench for core_ctx_sched with N_CTX=4 and default widths.
module tb_core_ctx_sched;
    localparam int N_CTX  = 4;
    localparam int SLOT_W = 7;
    localparam int TASK_W = 128;
    localparam int THR_W  = 4;
    localparam int CHL_W  = 3;

    logic                    clk;
    logic                    rst;
    logic                    start_en;
    logic                    cfg_deq_valid;
    logic [31:0]             cfg_deq_count;
    logic                    task_arvalid;
    logic                    task_rvalid;
    logic [TASK_W-1:0]       task_rdata;
    logic [SLOT_W-1:0]       task_rslot;
    logic [THR_W-1:0]        task_rthread;
    logic                    start_task_valid;
    logic                    start_task_ready;
    logic [SLOT_W-1:0]       start_task_slot;
    logic                    finish_task_valid;
    logic                    finish_task_ready;
    logic [SLOT_W-1:0]       finish_task_slot;
    logic [THR_W-1:0]        finish_task_thread;
    logic [CHL_W-1:0]        finish_task_num_children;
    logic                    finish_task_undo_log_write;
    logic [2**SLOT_W-1:0]    task_aborted;
    logic [N_CTX-1:0]        ctx_enq_fire, ctx_undo_fire, ctx_out_busy, ctx_mem_pending;
    logic [N_CTX-1:0]        app_start, app_done, app_idle, app_rst, ctx_busy;
    logic [N_CTX*TASK_W-1:0] app_task;
    logic [31:0]             num_dequeues;

    int n_cmp = 0;
    int n_bad = 0;
    int slots [4] = '{3, 9, 12, 40};
    int thrs  [4] = '{1, 2, 5, 7};
    int cnt;

    core_ctx_sched #(
        .N_CTX(N_CTX), .SLOT_W(SLOT_W), .TASK_W(TASK_W),
        .THREAD_W(THR_W), .CHILD_W(CHL_W), .RST_HOLD(6)
    ) dut (
        .clk(clk), .rst(rst), .start_en(start_en),
        .cfg_deq_valid(cfg_deq_valid), .cfg_deq_count(cfg_deq_count),
        .task_arvalid(task_arvalid), .task_rvalid(task_rvalid),
        .task_rdata(task_rdata), .task_rslot(task_rslot), .task_rthread(task_rthread),
        .start_task_valid(start_task_valid), .start_task_ready(start_task_ready),
        .start_task_slot(start_task_slot),
        .finish_task_valid(finish_task_valid), .finish_task_ready(finish_task_ready),
        .finish_task_slot(finish_task_slot), .finish_task_thread(finish_task_thread),
        .finish_task_num_children(finish_task_num_children),
        .finish_task_undo_log_write(finish_task_undo_log_write),
        .task_aborted(task_aborted),
        .ctx_enq_fire(ctx_enq_fire), .ctx_undo_fire(ctx_undo_fire),
        .ctx_out_busy(ctx_out_busy), .ctx_mem_pending(ctx_mem_pending),
        .app_start(app_start), .app_task(app_task), .app_done(app_done),
        .app_idle(app_idle), .app_rst(app_rst), .ctx_busy(ctx_busy),
        .num_dequeues(num_dequeues)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] tdat(input int s);
        return {32'hCAFE0000, 32'hDEAD0000, 32'h12345678, 32'(s)};
    endfunction

    initial begin
        rst = 1'b1; start_en = 1'b0; cfg_deq_valid = 1'b0; cfg_deq_count = '0;
        task_rvalid = 1'b0; task_rdata = '0; task_rslot = '0; task_rthread = '0;
        start_task_ready = 1'b0; finish_task_ready = 1'b0; task_aborted = '0;
        ctx_enq_fire = '0; ctx_undo_fire = '0; ctx_out_busy = '0; ctx_mem_pending = '0;
        app_done = '0; app_idle = '0;
        repeat (3) tick();
        #2;
        check_eq("rst_arvalid", task_arvalid, 0);
        check_eq("rst_svalid", start_task_valid, 0);
        check_eq("rst_fvalid", finish_task_valid, 0);
        check_eq("rst_app_rst", app_rst, 4'hF);
        check_eq("rst_busy", ctx_busy, 0);
        check_eq("rst_app_start", app_start, 0);
        check_eq("rst_ndeq", num_dequeues, 0);

        rst = 1'b0; start_en = 1'b1;
        tick(); #2;
        check_eq("post_rst_app_rst", app_rst, 0);
        check_eq("idle_arvalid", task_arvalid, 1);

        // Four back-to-back dequeues fill ctx0..3
        for (int k = 0; k < 4; k++) begin
            task_rvalid = 1'b1; task_rdata = tdat(slots[k]);
            task_rslot = SLOT_W'(slots[k]); task_rthread = THR_W'(thrs[k]);
            #2;
            check_eq("deq_arvalid", task_arvalid, 1);
            tick();
        end
        task_rvalid = 1'b0;
        #2;
        check_eq("full_arvalid", task_arvalid, 0);
        check_eq("full_busy", ctx_busy, 4'hF);
        check_eq("full_ndeq", num_dequeues, 4);
        check_eq("inform_svalid", start_task_valid, 1);
        check_eq("inform_slot0", start_task_slot, 3);
        tick(); #2;
        check_eq("slot_hold", start_task_slot, 3);

        // Release start handshakes: grants in ctx order with app_start pulses
        start_task_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(); #2;
            if (k < 3) check_eq("rr_slot", start_task_slot, 128'(slots[k+1]));
            check_eq("app_start_pulse", app_start, 128'(1 << k));
        end
        start_task_ready = 1'b0;
        check_eq("start_drained", start_task_valid, 0);
        check_eq("app_task1", app_task[TASK_W +: TASK_W], tdat(9));

        // Abort slot 9 while ctx1 runs
        task_aborted[9] = 1'b1;
        tick();
        task_aborted = '0;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            #2;
            if (app_rst[1]) cnt++;
            tick();
        end
        #2;
        check_eq("abort_rst_len", cnt, 6);
        check_eq("abort_wait_fvalid", finish_task_valid, 0);
        check_eq("abort_wait_busy", ctx_busy, 4'hF);
        app_idle[1] = 1'b1;
        tick(); #2;
        check_eq("abort_fvalid", finish_task_valid, 1);
        check_eq("abort_fslot", finish_task_slot, 9);
        check_eq("abort_fthread", finish_task_thread, 2);
        check_eq("abort_children", finish_task_num_children, 0);
        finish_task_ready = 1'b1;
        tick();
        finish_task_ready = 1'b0; app_idle = '0;
        #2;
        check_eq("abort_idle", ctx_busy, 4'b1101);

        // ctx2: children, undo flag, out_busy stall, then drain
        ctx_out_busy[2] = 1'b1; ctx_enq_fire[2] = 1'b1; ctx_undo_fire[2] = 1'b1;
        tick();
        ctx_undo_fire = '0;
        tick(); tick();
        ctx_enq_fire = '0; app_done[2] = 1'b1;
        tick();
        app_done = '0;
        #2;
        check_eq("finish_stall_a", finish_task_valid, 0);
        tick(); #2;
        check_eq("finish_stall_b", finish_task_valid, 0);
        ctx_out_busy = '0;
        #2;
        check_eq("c2_fvalid", finish_task_valid, 1);
        check_eq("c2_fslot", finish_task_slot, 12);
        check_eq("c2_children", finish_task_num_children, 3);
        check_eq("c2_undo", finish_task_undo_log_write, 1);
        finish_task_ready = 1'b1; ctx_mem_pending[2] = 1'b1;
        tick();
        finish_task_ready = 1'b0;
        #2;
        check_eq("drain_fvalid", finish_task_valid, 0);
        check_eq("drain_busy", ctx_busy, 4'b1101);
        tick(); #2;
        check_eq("drain_hold", ctx_busy, 4'b1101);
        ctx_mem_pending = '0;
        tick(); #2;
        check_eq("drain_exit", ctx_busy, 4'b1001);

        // ctx0 completes and is refilled first
        app_done[0] = 1'b1;
        tick();
        app_done = '0;
        #2;
        check_eq("c0_fvalid", finish_task_valid, 1);
        check_eq("c0_fslot", finish_task_slot, 3);
        check_eq("c0_fthread", finish_task_thread, 1);
        finish_task_ready = 1'b1;
        tick();
        finish_task_ready = 1'b0;
        #2;
        check_eq("c0_idle", ctx_busy, 4'b1000);
        check_eq("c0_arvalid", task_arvalid, 1);
        task_rvalid = 1'b1; task_rdata = tdat(50); task_rslot = 7'd50; task_rthread = 4'd3;
        tick();
        task_rvalid = 1'b0;
        #2;
        check_eq("redeq_busy", ctx_busy, 4'b1001);
        check_eq("redeq_slot", start_task_slot, 50);
        check_eq("redeq_ndeq", num_dequeues, 5);
        check_eq("redeq_task", app_task[0 +: TASK_W], tdat(50));

        // Reset mid-operation
        rst = 1'b1;
        tick(); #2;
        check_eq("mrst_busy", ctx_busy, 0);
        check_eq("mrst_app_rst", app_rst, 4'hF);
        check_eq("mrst_svalid", start_task_valid, 0);
        check_eq("mrst_ndeq", num_dequeues, 0);
        check_eq("mrst_arvalid", task_arvalid, 0);
        rst = 1'b0;
        tick(); #2;
        check_eq("mrst_release", app_rst, 0);

        // Budget of 2 dequeues
        cfg_deq_valid = 1'b1; cfg_deq_count = 32'd2;
        tick();
        cfg_deq_valid = 1'b0;
        task_rvalid = 1'b1; task_rslot = 7'd20; task_rdata = tdat(20);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            #2;
            if (task_arvalid && task_rvalid) cnt++;
            tick();
        end
        task_rvalid = 1'b0;
        #2;
        check_eq("budget_hs", cnt, 2);
        check_eq("budget_arvalid", task_arvalid, 0);
        check_eq("budget_ndeq", num_dequeues, 2);
        check_eq("budget_busy", ctx_busy, 4'b0011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
